// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: predicts fetch PC, carries the prediction
// through D/E, resolves branches/jumps in Execute, redirects and trains the table.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pcF,
  output logic            predTakenF,
  output logic [XLEN-1:0] predTargetF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            flushE,
  input  logic            validE,
  input  logic [XLEN-1:0] pcE,
  input  logic [2:0]      branchE,
  input  logic [1:0]      jumpE,
  input  logic            zeroE,
  input  logic [XLEN-1:0] targetE,
  input  logic [XLEN-1:0] pcPlus4E,
  output logic            redirectE,
  output logic [XLEN-1:0] redirectPCE,
  output logic [31:0]     branchCount,
  output logic [31:0]     mispredCount
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];

  logic            pred_taken_d_q, pred_taken_d_d;
  logic [XLEN-1:0] pred_target_d_q, pred_target_d_d;
  logic            pred_taken_e_q, pred_taken_e_d;
  logic [XLEN-1:0] pred_target_e_q, pred_target_e_d;

  logic [31:0]     branch_cnt_q, branch_cnt_d;
  logic [31:0]     mispred_cnt_q, mispred_cnt_d;

  logic            unused_pc_bits;
  assign unused_pc_bits = ^{pcF[1:0], pcE[1:0]};

  // Fetch lookup: asynchronous read, old contents during a same-cycle write.
  logic [IDXW-1:0] idx_f;
  logic [TAGW-1:0] tag_f;
  logic            hit_f;

  assign idx_f       = pcF[IDXW+1:2];
  assign tag_f       = pcF[XLEN-1:IDXW+2];
  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign predTakenF  = hit_f & ctr_q[idx_f][1];
  assign predTargetF = hit_f ? target_q[idx_f] : '0;

  // Prediction pipeline: flushD beats stallD.
  always_comb begin
    pred_taken_d_d  = pred_taken_d_q;
    pred_target_d_d = pred_target_d_q;
    if (flushD) begin
      pred_taken_d_d  = 1'b0;
      pred_target_d_d = '0;
    end else if (!stallD) begin
      pred_taken_d_d  = predTakenF;
      pred_target_d_d = predTargetF;
    end
    pred_taken_e_d  = flushE ? 1'b0 : pred_taken_d_q;
    pred_target_e_d = flushE ? '0   : pred_target_d_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_taken_d_q  <= 1'b0;
      pred_target_d_q <= '0;
      pred_taken_e_q  <= 1'b0;
      pred_target_e_q <= '0;
    end else begin
      pred_taken_d_q  <= pred_taken_d_d;
      pred_target_d_q <= pred_target_d_d;
      pred_taken_e_q  <= pred_taken_e_d;
      pred_target_e_q <= pred_target_e_d;
    end
  end

  // Execute resolution.
  logic is_beq, is_bne, is_jal, is_jalr, is_cond, act_taken, mispredict;

  always_comb begin
    is_beq     = (branchE == 3'b001);
    is_bne     = (branchE == 3'b010);
    is_jal     = (jumpE == 2'b01);
    is_jalr    = (jumpE == 2'b10);
    is_cond    = is_beq | is_bne;
    act_taken  = (is_beq & zeroE) | (is_bne & ~zeroE) | is_jal | is_jalr;
    mispredict = (pred_taken_e_q != act_taken)
               | (pred_taken_e_q & act_taken & (pred_target_e_q != targetE))
               | is_jalr;
    redirectE   = validE & mispredict;
    redirectPCE = (validE && act_taken) ? targetE : pcPlus4E;
  end

  // Training: JALR is never written into the table.
  logic [IDXW-1:0] idx_e;
  logic [TAGW-1:0] tag_e;
  logic            hit_e;
  logic            upd_en;
  logic            upd_valid;
  logic [TAGW-1:0] upd_tag;
  logic [XLEN-1:0] upd_target;
  logic [1:0]      upd_ctr;

  assign idx_e = pcE[IDXW+1:2];
  assign tag_e = pcE[XLEN-1:IDXW+2];
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  always_comb begin
    upd_en     = 1'b0;
    upd_valid  = valid_q[idx_e];
    upd_tag    = tag_q[idx_e];
    upd_target = target_q[idx_e];
    upd_ctr    = ctr_q[idx_e];
    if (validE && (is_cond || is_jal)) begin
      if (hit_e) begin
        upd_en = 1'b1;
        if (act_taken) begin
          upd_target = targetE;
          if (ctr_q[idx_e] != 2'b11) upd_ctr = ctr_q[idx_e] + 2'd1;
        end else if (ctr_q[idx_e] != 2'b00) begin
          upd_ctr = ctr_q[idx_e] - 2'd1;
        end
      end else if (act_taken) begin
        upd_en     = 1'b1;
        upd_valid  = 1'b1;
        upd_tag    = tag_e;
        upd_target = targetE;
        upd_ctr    = is_jal ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_en) begin
      valid_q[idx_e]  <= upd_valid;
      tag_q[idx_e]    <= upd_tag;
      target_q[idx_e] <= upd_target;
      ctr_q[idx_e]    <= upd_ctr;
    end
  end

  // Saturating statistics counters.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (validE && (is_cond || is_jal || is_jalr) && (branch_cnt_q != 32'hFFFF_FFFF))
      branch_cnt_d = branch_cnt_q + 32'd1;
    if (redirectE && (mispred_cnt_q != 32'hFFFF_FFFF))
      mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branchCount  = branch_cnt_q;
  assign mispredCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: scoreboard queue of expected values,
// immediate assertions at each comparison, one summary line at the end.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pcF;
  logic        predTakenF;
  logic [31:0] predTargetF;
  logic        stallD;
  logic        flushD;
  logic        flushE;
  logic        validE;
  logic [31:0] pcE;
  logic [2:0]  branchE;
  logic [1:0]  jumpE;
  logic        zeroE;
  logic [31:0] targetE;
  logic [31:0] pcPlus4E;
  logic        redirectE;
  logic [31:0] redirectPCE;
  logic [31:0] branchCount;
  logic [31:0] mispredCount;

  logic [31:0] exp_q[$];
  int          tests_run;
  int          tests_failed;
  logic [31:0] exp_bc;
  logic [31:0] exp_mc;

  branch_predictor #(.ENTRIES(16), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .pcF(pcF), .predTakenF(predTakenF),
    .predTargetF(predTargetF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .validE(validE), .pcE(pcE), .branchE(branchE), .jumpE(jumpE), .zeroE(zeroE),
    .targetE(targetE), .pcPlus4E(pcPlus4E), .redirectE(redirectE),
    .redirectPCE(redirectPCE), .branchCount(branchCount), .mispredCount(mispredCount)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: observed %h expected <empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        tests_failed++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // Driver tasks
  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_pred, input logic [31:0] exp_tgt);
    @(posedge clk); #1;
    validE = 1'b0;
    pcF    = pc;
    exp_q.push_back({31'd0, exp_pred});
    exp_q.push_back(exp_tgt);
    #1;
    check({tag, "/predTakenF"}, {31'd0, predTakenF});
    check({tag, "/predTargetF"}, predTargetF);
  endtask

  task automatic check_counts(input string tag);
    @(posedge clk); #1;
    validE = 1'b0;
    exp_q.push_back(exp_bc);
    exp_q.push_back(exp_mc);
    #1;
    check({tag, "/branchCount"}, branchCount);
    check({tag, "/mispredCount"}, mispredCount);
  endtask

  // One instruction through F (cycle 0), D (cycle 1) and E (cycle 2).
  task automatic run_br(input string tag, input logic [31:0] pc, input logic [2:0] br,
                        input logic [1:0] jmp, input logic zero, input logic [31:0] tgt,
                        input logic exp_pred, input logic [31:0] exp_ptgt,
                        input logic v, input logic fd, input logic fe);
    logic        e_pred;
    logic [31:0] e_ptgt;
    logic        act;
    logic        mis;
    logic        exp_redir;
    logic [31:0] exp_rpc;
    e_pred    = (fd || fe) ? 1'b0 : exp_pred;
    e_ptgt    = (fd || fe) ? 32'd0 : exp_ptgt;
    act       = (br == 3'd1 && zero) || (br == 3'd2 && !zero) || jmp == 2'd1 || jmp == 2'd2;
    mis       = (e_pred != act) || (e_pred && act && e_ptgt != tgt) || jmp == 2'd2;
    exp_redir = v && mis;
    exp_rpc   = (v && act) ? tgt : pc + 32'd4;
    @(posedge clk); #1;
    validE = 1'b0;
    pcF    = pc;
    flushD = fd;
    exp_q.push_back({31'd0, exp_pred});
    exp_q.push_back(exp_ptgt);
    exp_q.push_back({31'd0, exp_redir});
    exp_q.push_back(exp_rpc);
    #1;
    check({tag, "/predTakenF"}, {31'd0, predTakenF});
    check({tag, "/predTargetF"}, predTargetF);
    @(posedge clk); #1;
    flushD = 1'b0;
    pcF    = 32'd0;
    flushE = fe;
    @(posedge clk); #1;
    flushE   = 1'b0;
    validE   = v;
    pcE      = pc;
    branchE  = br;
    jumpE    = jmp;
    zeroE    = zero;
    targetE  = tgt;
    pcPlus4E = pc + 32'd4;
    #1;
    check({tag, "/redirectE"}, {31'd0, redirectE});
    check({tag, "/redirectPCE"}, redirectPCE);
    if (v && (br == 3'd1 || br == 3'd2 || jmp == 2'd1 || jmp == 2'd2)) exp_bc++;
    if (exp_redir) exp_mc++;
  endtask

  task automatic drive_e(input logic v, input logic [31:0] pc, input logic [1:0] jmp,
                         input logic [31:0] tgt);
    validE   = v;
    pcE      = pc;
    branchE  = 3'd0;
    jumpE    = jmp;
    zeroE    = 1'b0;
    targetE  = tgt;
    pcPlus4E = pc + 32'd4;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; exp_bc = 0; exp_mc = 0;
    rst_n = 1'b0; pcF = 32'h40; stallD = 1'b0; flushD = 1'b0; flushE = 1'b0;
    validE = 1'b0; pcE = 0; branchE = 0; jumpE = 0; zeroE = 0; targetE = 0; pcPlus4E = 32'h4;
    #2;
    exp_q.push_back(32'd0); check("reset/predTakenF", {31'd0, predTakenF});
    exp_q.push_back(32'd0); check("reset/predTargetF", predTargetF);
    exp_q.push_back(32'd0); check("reset/redirectE", {31'd0, redirectE});
    exp_q.push_back(32'd0); check("reset/branchCount", branchCount);
    exp_q.push_back(32'd0); check("reset/mispredCount", mispredCount);
    #20 rst_n = 1'b1;

    // Cold BEQ taken: allocates with ctr=10
    run_br("cold_beq", 32'h40, 3'd1, 2'd0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_counts("cold_beq");

    // Hysteresis: three taken BNEs, then two not-taken
    for (int i = 0; i < 3; i++)
      run_br("bne_taken", 32'h40, 3'd2, 2'd0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
    run_br("bne_nt1", 32'h40, 3'd2, 2'd0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
    run_br("bne_nt2", 32'h40, 3'd2, 2'd0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
    lookup("after_nt2", 32'h40, 1'b0, 32'h80);
    check_counts("hysteresis");

    // Asynchronous reset while a taken BEQ sits in Execute
    @(posedge clk); #1;
    pcF = 32'h0;
    drive_e(1'b1, 32'h40, 2'd0, 32'h80);
    branchE = 3'd1; zeroE = 1'b1;
    #2 rst_n = 1'b0;
    #1 validE = 1'b0; pcF = 32'h40;
    exp_bc = 0; exp_mc = 0;
    #1;
    exp_q.push_back(32'd0); check("midreset/predTakenF", {31'd0, predTakenF});
    exp_q.push_back(32'd0); check("midreset/predTargetF", predTargetF);
    exp_q.push_back(32'd0); check("midreset/redirectE", {31'd0, redirectE});
    exp_q.push_back(32'd0); check("midreset/branchCount", branchCount);
    exp_q.push_back(32'd0); check("midreset/mispredCount", mispredCount);
    @(posedge clk); #3 rst_n = 1'b1;
    lookup("post_reset_40", 32'h40, 1'b0, 32'h0);

    // JALR: always redirects, never allocates
    run_br("jalr1", 32'h100, 3'd0, 2'd2, 1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    run_br("jalr2", 32'h100, 3'd0, 2'd2, 1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    lookup("jalr_noalloc", 32'h100, 1'b0, 32'h0);
    check_counts("jalr");

    // Alias at index 0 and wrong-target redirect
    run_br("jal40", 32'h40, 3'd0, 2'd1, 1'b0, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    run_br("jal80", 32'h80, 3'd0, 2'd1, 1'b0, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    lookup("alias_40_miss", 32'h40, 1'b0, 32'h0);
    run_br("jal80_wrongtgt", 32'h80, 3'd0, 2'd1, 1'b0, 32'h404, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
    run_br("alias_nt", 32'h40, 3'd1, 2'd0, 1'b0, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    lookup("alias_nt_keep", 32'h80, 1'b1, 32'h404);

    // Pipeline control: flushD / flushE drop the prediction
    run_br("flushD", 32'h80, 3'd0, 2'd1, 1'b0, 32'h404, 1'b1, 32'h404, 1'b1, 1'b1, 1'b0);
    run_br("flushE", 32'h80, 3'd0, 2'd1, 1'b0, 32'h404, 1'b1, 32'h404, 1'b1, 1'b0, 1'b1);

    // stallD holds the D prediction for two cycles
    lookup("stall_c0", 32'h80, 1'b1, 32'h404);
    @(posedge clk); #1 pcF = 32'h0; stallD = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 stallD = 1'b0;
    @(posedge clk); #1;
    drive_e(1'b1, 32'h80, 2'd1, 32'h404);
    exp_q.push_back(32'd0); exp_q.push_back(32'h404);
    #1;
    check("stall_held/redirectE", {31'd0, redirectE});
    check("stall_held/redirectPCE", redirectPCE);
    exp_bc++;
    @(posedge clk); #1;
    exp_q.push_back(32'd1); exp_q.push_back(32'h404);
    #1;
    check("stall_release/redirectE", {31'd0, redirectE});
    check("stall_release/redirectPCE", redirectPCE);
    exp_bc++; exp_mc++;

    // Simultaneous stallD and flushD: the flush clears D
    lookup("stflush_c0", 32'h80, 1'b1, 32'h404);
    @(posedge clk); #1 pcF = 32'h0; stallD = 1'b1; flushD = 1'b1;
    @(posedge clk); #1 stallD = 1'b0; flushD = 1'b0;
    @(posedge clk); #1;
    drive_e(1'b1, 32'h80, 2'd1, 32'h404);
    exp_q.push_back(32'd1);
    #1;
    check("stall_flush/redirectE", {31'd0, redirectE});
    exp_bc++; exp_mc++;

    // validE=0 suppresses redirect, training and counting
    run_br("bubble", 32'h40, 3'd0, 2'd1, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    lookup("bubble_noalloc", 32'h40, 1'b0, 32'h0);
    lookup("bubble_keep80", 32'h80, 1'b1, 32'h404);
    check_counts("pipeline");

    // Random misses and random bubbles
    for (int i = 0; i < 6; i++)
      lookup("rand_miss", 32'h1000_0000 | (32'($urandom_range(0, 1023)) << 2), 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      validE   = 1'b0;
      branchE  = 3'($urandom_range(0, 7));
      jumpE    = 2'($urandom_range(0, 3));
      zeroE    = 1'($urandom_range(0, 1));
      pcE      = $urandom;
      targetE  = $urandom;
      pcPlus4E = $urandom;
      exp_q.push_back(32'd0);
      exp_q.push_back(pcPlus4E);
      #1;
      check("rand_bubble/redirectE", {31'd0, redirectE});
      check("rand_bubble/redirectPCE", redirectPCE);
    end
    check_counts("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
